// File: rtl/audio_recorder_if.sv
// Capture-side bus of audio_recorder: controller commands, codec I2S pins and the SRAM write port.
interface audio_recorder_if #(
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned DATA_W = 16
) ();
   logic              start;
   logic              pause;
   logic              stop;
   logic              bclk;
   logic              lrc;
   logic              adcdat;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic              we;
   logic [ADDR_W:0]   len;
   logic              full;
   logic              busy;

   modport master (
      output start, pause, stop, bclk, lrc, adcdat,
      input  addr, data, we, len, full, busy
   );

   modport slave (
      input  start, pause, stop, bclk, lrc, adcdat,
      output addr, data, we, len, full, busy
   );
endinterface

// File: rtl/audio_recorder.sv
// Deserialises I2S ADC samples (codec master) and writes them to consecutive SRAM words.
// Define AUDIO_RECORDER_STEREO_EN to also capture the right channel as interleaved L/R words.
module audio_recorder #(
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned DATA_W = 16
) (
   input  logic            i_clk,
   input  logic            i_rst,
   audio_recorder_if.slave bus
);
   localparam int unsigned        CNT_W     = $clog2(DATA_W);
   localparam int unsigned        LEN_W     = ADDR_W + 1;
   localparam logic [ADDR_W-1:0]  ADDR_LAST = {ADDR_W{1'b1}};
   localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, WAIT_LRC, SKIP, SHIFT, WRITE, PAUSE} state_e;

   state_e            state_q, state_n;
   logic [2:0]        bclk_sync, lrc_sync;
   logic [1:0]        dat_sync;
   logic              bclk_rise, lrc_fall, frame_edge;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [DATA_W-1:0] data_q, data_n;
   logic [DATA_W-1:0] shreg_q, shreg_n;
   logic [CNT_W-1:0]  cnt_q, cnt_n;
   logic [LEN_W-1:0]  len_q, len_n;
   logic              full_q, full_n;
   logic              we_q, we_n;
   logic              busy_q, busy_n;
   logic              pend_q, pend_n;
`ifdef AUDIO_RECORDER_STEREO_EN
   logic              lrc_rise;
   logic              chan_q, chan_n;
   logic              spend_q, spend_n;
`endif

   // Codec pins are asynchronous: two-stage synchronisers plus one history bit for edges
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         bclk_sync <= '0;
         lrc_sync  <= '0;
         dat_sync  <= '0;
      end else begin
         bclk_sync <= {bclk_sync[1:0], bus.bclk};
         lrc_sync  <= {lrc_sync[1:0], bus.lrc};
         dat_sync  <= {dat_sync[0], bus.adcdat};
      end
   end

   assign bclk_rise = bclk_sync[1] & ~bclk_sync[2];
   assign lrc_fall  = ~lrc_sync[1] & lrc_sync[2];
`ifdef AUDIO_RECORDER_STEREO_EN
   assign lrc_rise   = lrc_sync[1] & ~lrc_sync[2];
   assign frame_edge = chan_q ? lrc_rise : lrc_fall;
`else
   assign frame_edge = lrc_fall;
`endif

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) state_q <= IDLE;
      else        state_q <= state_n;
   end

   // Next state and next datapath values; stop > pause > start
   always_comb begin
      state_n = state_q;
      addr_n  = addr_q;
      data_n  = data_q;
      shreg_n = shreg_q;
      cnt_n   = cnt_q;
      len_n   = len_q;
      full_n  = full_q;
      we_n    = 1'b0;
      pend_n  = pend_q;
`ifdef AUDIO_RECORDER_STEREO_EN
      chan_n  = chan_q;
      spend_n = spend_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.start && !bus.stop) begin
               addr_n  = '0;
               len_n   = '0;
               full_n  = 1'b0;
               state_n = WAIT_LRC;
            end
         end
         WAIT_LRC: if (frame_edge) state_n = SKIP;
         SKIP: begin
            // first BCLK after the LRC edge is the I2S one-bit delay
            if (bclk_rise) begin
               cnt_n   = '0;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (bclk_rise) begin
               shreg_n = {shreg_q[DATA_W-2:0], dat_sync[1]};
               cnt_n   = cnt_q + CNT_W'(1);
               if (cnt_q == BIT_LAST) begin
                  data_n  = shreg_n;
                  we_n    = 1'b1;
                  state_n = WRITE;
               end
            end
         end
         WRITE: begin
            len_n = len_q + LEN_W'(1);
            if (addr_q == ADDR_LAST) begin
               full_n  = 1'b1;
               state_n = IDLE;
            end else begin
               addr_n = addr_q + ADDR_W'(1);
`ifdef AUDIO_RECORDER_STEREO_EN
               if (!chan_q) begin
                  chan_n  = 1'b1;
                  state_n = WAIT_LRC;
               end else if (spend_q || bus.stop) begin
                  state_n = IDLE;
               end else if (pend_q || bus.pause) begin
                  state_n = PAUSE;
               end else begin
                  chan_n  = 1'b0;
                  state_n = WAIT_LRC;
               end
`else
               state_n = (pend_q || bus.pause) ? PAUSE : WAIT_LRC;
`endif
            end
         end
         PAUSE: if (bus.start && !bus.stop && !bus.pause) state_n = WAIT_LRC;
         default: state_n = IDLE;
      endcase

      if (bus.pause && (state_q inside {WAIT_LRC, SKIP, SHIFT, WRITE})) pend_n = 1'b1;

`ifdef AUDIO_RECORDER_STEREO_EN
      // mid-pair stops are deferred until the right word has been written
      if (bus.stop && (state_q inside {IDLE, PAUSE} || (state_q == WAIT_LRC && !chan_q)))
         state_n = IDLE;
      else if (bus.stop && (state_q inside {WAIT_LRC, SKIP, SHIFT, WRITE}))
         spend_n = 1'b1;
      if (state_n inside {IDLE, PAUSE}) begin
         chan_n  = 1'b0;
         spend_n = 1'b0;
      end
`else
      if (bus.stop) begin
         state_n = IDLE;
         we_n    = 1'b0;
         data_n  = data_q;
      end
`endif
      if (state_n inside {IDLE, PAUSE}) pend_n = 1'b0;
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         addr_q  <= '0;
         data_q  <= '0;
         shreg_q <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         full_q  <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         pend_q  <= 1'b0;
`ifdef AUDIO_RECORDER_STEREO_EN
         chan_q  <= 1'b0;
         spend_q <= 1'b0;
`endif
      end else begin
         addr_q  <= addr_n;
         data_q  <= data_n;
         shreg_q <= shreg_n;
         cnt_q   <= cnt_n;
         len_q   <= len_n;
         full_q  <= full_n;
         we_q    <= we_n;
         busy_q  <= busy_n;
         pend_q  <= pend_n;
`ifdef AUDIO_RECORDER_STEREO_EN
         chan_q  <= chan_n;
         spend_q <= spend_n;
`endif
      end
   end

   assign bus.addr = addr_q;
   assign bus.data = data_q;
   assign bus.we   = we_q;
   assign bus.len  = len_q;
   assign bus.full = full_q;
   assign bus.busy = busy_q;
endmodule

// File: tb/tb_audio_recorder.sv
// Bench for audio_recorder: directed frame table plus randomised frames against a frame-level model.
module tb_audio_recorder;
   localparam int unsigned AW    = 3;
   localparam int unsigned DW    = 16;
   localparam int          SLOTS = 20;
   localparam int          BH    = 47;
   localparam int          AMAX  = (1 << AW) - 1;

   typedef struct {
      int          pre;
      int          cmd;
      int          bitn;
      logic [15:0] l;
      logic [15:0] r;
      int          nwe;
      int          wa;
      logic [15:0] wd;
      int          wa2;
      logic [15:0] wd2;
      int          len;
      int          addr;
      logic        busy;
      logic        full;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [AW-1:0] wa_q[$];
   logic [DW-1:0] wd_q[$];
   int            ea_q[$];
   logic [DW-1:0] ed_q[$];
   vec_t          vecs[$];

   int m_st, m_addr, m_len;
   logic m_full;

   audio_recorder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   audio_recorder #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .i_clk (clk),
      .i_rst (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.we === 1'b1) begin
         wa_q.push_back(bus.addr);
         wd_q.push_back(bus.data);
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", name, got, exp);
      end
   endtask

   task automatic pulse(input int which);
      @(posedge clk);
      #1;
      if (which == 0) bus.start = 1'b1;
      else if (which == 1) bus.pause = 1'b1;
      else bus.stop = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.pause = 1'b0;
      bus.stop  = 1'b0;
   endtask

   task automatic do_pre(input int pre);
      if (pre == 2) begin
         pulse(2);
         repeat (2) @(posedge clk);
      end
      if (pre != 0) begin
         pulse(0);
         repeat (2) @(posedge clk);
      end
   endtask

   // cmd: 1 pause, 2 stop, 3 asynchronous reset, injected in the given left-channel slot
   task automatic inject(input int cmd);
      if (cmd == 1) pulse(1);
      else if (cmd == 2) pulse(2);
      else if (cmd == 3) begin
         #3 rst_n = 1'b0;
         #2;
         check("rst_addr", 32'(bus.addr), 32'd0);
         check("rst_data", 32'(bus.data), 32'd0);
         check("rst_we",   32'(bus.we),   32'd0);
         check("rst_len",  32'(bus.len),  32'd0);
         check("rst_full", 32'(bus.full), 32'd0);
         check("rst_busy", 32'(bus.busy), 32'd0);
         repeat (2) @(posedge clk);
         #3 rst_n = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int cmd, input int bitn);
      logic [15:0] w;
      for (int h = 0; h < 2; h++) begin
         w = (h == 0) ? l : r;
         for (int k = 0; k < SLOTS; k++) begin
            bus.lrc = (h == 1);
            if (k >= 1 && k <= DW) bus.adcdat = w[DW-k];
            else                   bus.adcdat = 1'($urandom);
            if (h == 0 && k == bitn && cmd != 0) inject(cmd);
            #BH bus.bclk = 1'b1;
            #BH bus.bclk = 1'b0;
         end
      end
      repeat (8) @(posedge clk);
      @(negedge clk);
   endtask

   function automatic vec_t mk(input int pre, input int cmd, input int bitn,
                               input logic [15:0] l, input logic [15:0] r, input int nwe,
                               input int wa, input logic [15:0] wd, input int wa2,
                               input logic [15:0] wd2, input int len, input int addr,
                               input logic busy, input logic full);
      vec_t v;
      v.pre = pre; v.cmd = cmd; v.bitn = bitn; v.l = l; v.r = r; v.nwe = nwe;
      v.wa = wa; v.wd = wd; v.wa2 = wa2; v.wd2 = wd2; v.len = len; v.addr = addr;
      v.busy = busy; v.full = full;
      return v;
   endfunction

   task automatic check_state(input int len, input int addr, input logic busy, input logic full);
      check("len",  32'(bus.len),  32'(len));
      check("addr", 32'(bus.addr), 32'(addr));
      check("busy", 32'(bus.busy), 32'(busy));
      check("full", 32'(bus.full), 32'(full));
   endtask

   // Frame-level reference: 0 idle, 1 recording, 2 paused
   task automatic model_pre(input int pre);
      if (pre == 2) m_st = 0;
      if (pre != 0) begin
         if (m_st == 0) begin
            m_addr = 0; m_len = 0; m_full = 1'b0; m_st = 1;
         end else if (m_st == 2) m_st = 1;
      end
   endtask

   task automatic model_frame(input logic [15:0] l, input logic [15:0] r, input int cmd);
      ea_q.delete();
      ed_q.delete();
      if (m_st == 1) begin
`ifdef AUDIO_RECORDER_STEREO_EN
         ea_q.push_back(m_addr);     ed_q.push_back(l);
         ea_q.push_back(m_addr + 1); ed_q.push_back(r);
         m_len += 2;
         if (m_addr + 1 == AMAX) begin
            m_full = 1'b1; m_addr = AMAX; m_st = 0;
         end else begin
            m_addr += 2;
            if (cmd == 2) m_st = 0;
            else if (cmd == 1) m_st = 2;
         end
`else
         if (cmd == 2) m_st = 0;
         else begin
            ea_q.push_back(m_addr); ed_q.push_back(l);
            m_len++;
            if (m_addr == AMAX) begin
               m_full = 1'b1; m_st = 0;
            end else begin
               m_addr++;
               if (cmd == 1) m_st = 2;
            end
         end
`endif
      end else if (cmd == 2) m_st = 0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
      bus.bclk = 1'b0; bus.lrc = 1'b1; bus.adcdat = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_we", 32'(bus.we), 32'd0);
      check("reset_data", 32'(bus.data), 32'd0);
      check_state(0, 0, 1'b0, 1'b0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);

`ifdef AUDIO_RECORDER_STEREO_EN
      vecs.push_back(mk(2, 0, 0, 16'h1111, 16'h2222, 2, 0, 16'h1111, 1, 16'h2222, 2, 2, 1'b1, 1'b0));
      vecs.push_back(mk(0, 1, 3, 16'h3333, 16'h4444, 2, 2, 16'h3333, 3, 16'h4444, 4, 4, 1'b1, 1'b0));
      vecs.push_back(mk(0, 0, 0, 16'h5555, 16'h6666, 0, 0, 16'h0,    0, 16'h0,    4, 4, 1'b1, 1'b0));
      vecs.push_back(mk(1, 2, 6, 16'h7777, 16'h8888, 2, 4, 16'h7777, 5, 16'h8888, 6, 6, 1'b0, 1'b0));
      vecs.push_back(mk(2, 0, 0, 16'h9999, 16'hAAAA, 2, 0, 16'h9999, 1, 16'hAAAA, 2, 2, 1'b1, 1'b0));
      vecs.push_back(mk(0, 3, 8, 16'hC0DE, 16'hFACE, 0, 0, 16'h0,    0, 16'h0,    0, 0, 1'b0, 1'b0));
`else
      vecs.push_back(mk(1, 0, 0,  16'hA5C3, 16'hDEAD, 1, 0, 16'hA5C3, 0, 16'h0, 1, 1, 1'b1, 1'b0));
      vecs.push_back(mk(0, 0, 0,  16'h0001, 16'hDEAD, 1, 1, 16'h0001, 0, 16'h0, 2, 2, 1'b1, 1'b0));
      vecs.push_back(mk(0, 0, 0,  16'h8000, 16'hDEAD, 1, 2, 16'h8000, 0, 16'h0, 3, 3, 1'b1, 1'b0));
      vecs.push_back(mk(2, 0, 0,  16'h0F0F, 16'hDEAD, 1, 0, 16'h0F0F, 0, 16'h0, 1, 1, 1'b1, 1'b0));
      vecs.push_back(mk(0, 2, 10, 16'h5555, 16'hDEAD, 0, 0, 16'h0,    0, 16'h0, 1, 1, 1'b0, 1'b0));
      vecs.push_back(mk(1, 0, 0,  16'h3C3C, 16'hDEAD, 1, 0, 16'h3C3C, 0, 16'h0, 1, 1, 1'b1, 1'b0));
      vecs.push_back(mk(0, 3, 8,  16'h7777, 16'hDEAD, 0, 0, 16'h0,    0, 16'h0, 0, 0, 1'b0, 1'b0));
      vecs.push_back(mk(1, 1, 5,  16'h1234, 16'hDEAD, 1, 0, 16'h1234, 0, 16'h0, 1, 1, 1'b1, 1'b0));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 0, 0, 16'h9999, 16'h6666, 0, 0, 16'h0, 0, 16'h0, 1, 1, 1'b1, 1'b0));
      vecs.push_back(mk(1, 0, 0,  16'hBEEF, 16'hDEAD, 1, 1, 16'hBEEF, 0, 16'h0, 2, 2, 1'b1, 1'b0));
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk((i == 0) ? 2 : 0, 0, 0, 16'hF000 + 16'(i), 16'hDEAD, 1, i,
                           16'hF000 + 16'(i), 0, 16'h0, i + 1, (i < 7) ? i + 1 : 7,
                           (i < 7), (i == 7)));
      vecs.push_back(mk(0, 0, 0,  16'hAAAA, 16'hDEAD, 0, 0, 16'h0,    0, 16'h0, 8, 7, 1'b0, 1'b1));
`endif

      foreach (vecs[i]) begin
         wa_q.delete();
         wd_q.delete();
         do_pre(vecs[i].pre);
         send_frame(vecs[i].l, vecs[i].r, vecs[i].cmd, vecs[i].bitn);
         check("nwe", 32'(wa_q.size()), 32'(vecs[i].nwe));
         if (vecs[i].nwe >= 1 && wa_q.size() >= 1) begin
            check("wr_addr", 32'(wa_q[0]), 32'(vecs[i].wa));
            check("wr_data", 32'(wd_q[0]), 32'(vecs[i].wd));
         end
         if (vecs[i].nwe == 2 && wa_q.size() >= 2) begin
            check("wr_addr2", 32'(wa_q[1]), 32'(vecs[i].wa2));
            check("wr_data2", 32'(wd_q[1]), 32'(vecs[i].wd2));
         end
         check_state(vecs[i].len, vecs[i].addr, vecs[i].busy, vecs[i].full);
      end

      // randomised frames against the frame-level model, from a fresh reset
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      m_st = 0; m_addr = 0; m_len = 0; m_full = 1'b0;
      for (int n = 0; n < 40; n++) begin
         int pre, cmd, roll, bitn;
         logic [15:0] l, r;
         roll = $urandom_range(0, 99);
         pre  = (n == 0 || roll < 25) ? 1 : (roll < 30) ? 2 : 0;
         roll = $urandom_range(0, 99);
         cmd  = (roll < 10) ? 1 : (roll < 18) ? 2 : 0;
         bitn = $urandom_range(1, DW);
         l    = 16'($urandom);
         r    = 16'($urandom);
         wa_q.delete();
         wd_q.delete();
         do_pre(pre);
         model_pre(pre);
         send_frame(l, r, cmd, bitn);
         model_frame(l, r, cmd);
         check("rnd_nwe", 32'(wa_q.size()), 32'(ea_q.size()));
         for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
            check("rnd_addr", 32'(wa_q[i]), 32'(ea_q[i]));
            check("rnd_data", 32'(wd_q[i]), 32'(ed_q[i]));
         end
         check_state(m_len, m_addr, (m_st != 0), m_full);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
